// File: rtl/plug_pkg.sv
// Shared types and constants for the programmable plugboard controller.
package plug_pkg;

    localparam int NUM_LETTERS = 26;
    localparam int LW          = 5;

    typedef logic [LW-1:0] letter_t;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    function automatic logic is_letter(letter_t l);
        return (l >= letter_t'(1)) && (l <= letter_t'(NUM_LETTERS));
    endfunction

endpackage

// File: rtl/plug_cfg_ctrl_if.sv
// Configuration and lookup bus between software/rotor pipeline and the plugboard.
interface plug_cfg_ctrl_if;

    logic             clr_req;
    logic             pair_valid;
    plug_pkg::letter_t pair_a;
    plug_pkg::letter_t pair_b;
    logic             pair_ready;
    logic             pair_err;
    logic             pair_ok;
    logic             in_valid;
    plug_pkg::letter_t in_letter;
    logic             in_ready;
    logic             out_valid;
    plug_pkg::letter_t out_letter;
    logic [3:0]       pair_count;
    logic             busy;

    modport master (
        output clr_req, pair_valid, pair_a, pair_b, in_valid, in_letter,
        input  pair_ready, pair_err, pair_ok, in_ready, out_valid, out_letter,
               pair_count, busy
    );

    modport slave (
        input  clr_req, pair_valid, pair_a, pair_b, in_valid, in_letter,
        output pair_ready, pair_err, pair_ok, in_ready, out_valid, out_letter,
               pair_count, busy
    );

endinterface

// File: rtl/plug_map_table.sv
// 26-entry letter substitution map: dual-entry write, combinational reads.
module plug_map_table
    import plug_pkg::*;
(
    input  logic    clk,
    input  logic    we_a,
    input  letter_t addr_a,
    input  letter_t data_a,
    input  logic    we_b,
    input  letter_t addr_b,
    input  letter_t data_b,
    input  letter_t rd_addr_a,
    input  letter_t rd_addr_b,
    output letter_t rd_data_a,
    output letter_t rd_data_b
);

    letter_t map [1:NUM_LETTERS];

    always_ff @(posedge clk) begin
        if (we_a) map[addr_a] <= data_a;
        if (we_b) map[addr_b] <= data_b;
    end

    // Non-letters pass through unchanged, so callers never see an unmapped entry.
    always_comb begin
        rd_data_a = is_letter(rd_addr_a) ? map[rd_addr_a] : rd_addr_a;
        rd_data_b = is_letter(rd_addr_b) ? map[rd_addr_b] : rd_addr_b;
    end

endmodule

// File: rtl/plug_cfg_ctrl.sv
// Plugboard controller: clear sweep, pair validation/install, 1-cycle lookups.
module plug_cfg_ctrl
    import plug_pkg::*;
#(
    parameter int MAX_PAIRS = 10
) (
    input logic            clk,
    input logic            rst_n,
    plug_cfg_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    letter_t    idx_q;
    logic [3:0] count_q;
    logic       pair_err_q, pair_ok_q, out_valid_q;
    letter_t    out_letter_q;

    logic       pair_rdy, in_rdy, busy_c, clr_go, pair_acc, in_acc, pair_bad;
    logic       we_a, we_b;
    letter_t    addr_a, data_a, addr_b, data_b, rd_addr_a, rd_data_a, rd_data_b;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (idx_q == letter_t'(NUM_LETTERS)) state_d = READY;
            READY:   if (bus.clr_req) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy_c   = 1'b0;
        pair_rdy = 1'b0;
        in_rdy   = 1'b0;
        clr_go   = 1'b0;
        we_a     = 1'b0;
        we_b     = 1'b0;
        addr_a   = bus.pair_a;
        data_a   = bus.pair_b;
        addr_b   = bus.pair_b;
        data_b   = bus.pair_a;
        case (state_q)
            CLEAR: begin
                busy_c = 1'b1;
                we_a   = 1'b1;
                addr_a = idx_q;
                data_a = idx_q;
            end
            READY: begin
                clr_go   = bus.clr_req;
                pair_rdy = !bus.clr_req && bus.pair_valid;
                in_rdy   = !bus.clr_req && !bus.pair_valid && bus.in_valid;
                we_a     = pair_rdy && !pair_bad;
                we_b     = pair_rdy && !pair_bad;
            end
            default: busy_c = 1'b1;
        endcase
    end

    assign pair_acc  = pair_rdy;
    assign in_acc    = in_rdy;
    // Port a serves the lookup whenever no pair is offered, so one read covers both uses.
    assign rd_addr_a = bus.pair_valid ? bus.pair_a : bus.in_letter;

    assign pair_bad = (bus.pair_a == bus.pair_b)
                    || !is_letter(bus.pair_a) || !is_letter(bus.pair_b)
                    || (rd_data_a != bus.pair_a) || (rd_data_b != bus.pair_b)
                    || (count_q == 4'(MAX_PAIRS));

    plug_map_table u_map (
        .clk       (clk),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .data_a    (data_a),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (bus.pair_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= letter_t'(1);
            count_q      <= '0;
            pair_err_q   <= 1'b0;
            pair_ok_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_letter_q <= '0;
        end else begin
            idx_q       <= (state_q == CLEAR) ? idx_q + letter_t'(1) : letter_t'(1);
            pair_err_q  <= pair_acc && pair_bad;
            pair_ok_q   <= pair_acc && !pair_bad;
            out_valid_q <= in_acc;
            if (in_acc) out_letter_q <= rd_data_a;
            if (clr_go)                     count_q <= '0;
            else if (pair_acc && !pair_bad) count_q <= count_q + 4'd1;
        end
    end

    assign bus.pair_ready = pair_rdy;
    assign bus.in_ready   = in_rdy;
    assign bus.busy       = busy_c;
    assign bus.pair_err   = pair_err_q;
    assign bus.pair_ok    = pair_ok_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign bus.pair_count = count_q;

endmodule

// File: tb/tb_plug_cfg_ctrl.sv
// Bench for plug_cfg_ctrl: two instances (MAX_PAIRS 10 and 2) driven in lockstep.
module tb_plug_cfg_ctrl;
    import plug_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    clr_req = 1'b0, pair_valid = 1'b0, in_valid = 1'b0;
    letter_t pair_a = '0, pair_b = '0, in_letter = '0;

    plug_cfg_ctrl_if bus0 ();
    plug_cfg_ctrl_if bus1 ();

    assign bus0.clr_req = clr_req;     assign bus1.clr_req = clr_req;
    assign bus0.pair_valid = pair_valid; assign bus1.pair_valid = pair_valid;
    assign bus0.pair_a = pair_a;       assign bus1.pair_a = pair_a;
    assign bus0.pair_b = pair_b;       assign bus1.pair_b = pair_b;
    assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
    assign bus0.in_letter = in_letter; assign bus1.in_letter = in_letter;

    plug_cfg_ctrl #(.MAX_PAIRS(10)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    plug_cfg_ctrl #(.MAX_PAIRS(2))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic       pr, ir, err, ok, ov, busy;
        letter_t    ol;
        logic [3:0] cnt;
    } obs_t;

    obs_t o [2];
    int   vectors = 0;
    int   errors  = 0;
    int   mx  [2] = '{10, 2};
    int   mp  [2][32];
    int   cnt [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        o[0] = '{pr: bus0.pair_ready, ir: bus0.in_ready, err: bus0.pair_err, ok: bus0.pair_ok,
                 ov: bus0.out_valid, busy: bus0.busy, ol: bus0.out_letter, cnt: bus0.pair_count};
        o[1] = '{pr: bus1.pair_ready, ir: bus1.in_ready, err: bus1.pair_err, ok: bus1.pair_ok,
                 ov: bus1.out_valid, busy: bus1.busy, ol: bus1.out_letter, cnt: bus1.pair_count};
    endtask

    // Reference: plugboard as a list of swaps; a pair is legal only if both letters are free.
    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mp[d][i] = i;
            cnt[d] = 0;
        end
    endfunction

    function automatic bit model_load(int d, int a, int b);
        bit ok;
        ok = (a != b) && (a >= 1) && (a <= 26) && (b >= 1) && (b <= 26)
             && (mp[d][a] == a) && (mp[d][b] == b) && (cnt[d] < mx[d]);
        if (ok) begin
            mp[d][a] = b;
            mp[d][b] = a;
            cnt[d]++;
        end
        return ok;
    endfunction

    task automatic wait_idle(output int n);
        n = 0;
        sample();
        while ((o[0].busy || o[1].busy) && n < 40) begin
            step();
            sample();
            n++;
        end
    endtask

    task automatic do_reset();
        int n;
        clr_req = 1'b0; pair_valid = 1'b0; in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_idle(n);
        model_clear();
    endtask

    // Offers one pair; afterwards o[] holds the result-cycle view.
    task automatic load(int a, int b, output bit exp [2]);
        pair_a = letter_t'(a);
        pair_b = letter_t'(b);
        pair_valid = 1'b1;
        step();
        pair_valid = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) exp[d] = model_load(d, a, b);
    endtask

    task automatic lookup(int l);
        in_letter = letter_t'(l);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sample();
    endtask

    task automatic check_loads(string tag, int a, int b);
        bit exp [2];
        load(a, b, exp);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].ok, o[d].err} !== {exp[d], !exp[d]}) begin
                errors++;
                $display("FAIL %s pair(%0d,%0d) dut%0d ok/err got %b%b exp %b%b",
                         tag, a, b, d, o[d].ok, o[d].err, exp[d], !exp[d]);
            end
        end
    endtask

    task automatic check_lookups(string tag, int l);
        lookup(l);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ov !== 1'b1 || o[d].ol !== letter_t'(mp[d][l])) begin
                errors++;
                $display("FAIL %s lookup %0d dut%0d got v=%b %0d exp v=1 %0d",
                         tag, l, d, o[d].ov, o[d].ol, mp[d][l]);
            end
        end
    endtask

    task automatic check_count(string tag);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].cnt !== 4'(cnt[d])) begin
                errors++;
                $display("FAIL %s pair_count dut%0d got %0d exp %0d", tag, d, o[d].cnt, cnt[d]);
            end
        end
    endtask

    task automatic check_sweep(string tag, int n, int ready_during_busy);
        vectors++;
        if (n !== 26 || ready_during_busy !== 0) begin
            errors++;
            $display("FAIL %s sweep got %0d busy cycles (%0d ready) exp 26 (0)",
                     tag, n, ready_during_busy);
        end
    endtask

    task automatic test_reset();
        int n = 0, rdy = 0;
        rst_n = 1'b0;
        step();
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].busy, o[d].pr, o[d].ir, o[d].ov, o[d].err, o[d].ok, o[d].ol, o[d].cnt}
                !== 15'h4000) begin
                errors++;
                $display("FAIL reset_state dut%0d got %h exp 4000", d,
                         {o[d].busy, o[d].pr, o[d].ir, o[d].ov, o[d].err, o[d].ok, o[d].ol, o[d].cnt});
            end
        end
        in_letter = letter_t'(5);
        in_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        sample();
        while ((o[0].busy || o[1].busy) && n < 40) begin
            if (o[0].ir || o[1].ir || o[0].ov || o[1].ov) rdy++;
            step();
            sample();
            n++;
        end
        check_sweep("reset", n, rdy);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ir !== 1'b1) begin
                errors++;
                $display("FAIL first_in_ready dut%0d got %b exp 1", d, o[d].ir);
            end
        end
        model_clear();
        step();
        in_valid = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ov !== 1'b1 || o[d].ol !== letter_t'(5)) begin
                errors++;
                $display("FAIL held_lookup dut%0d got v=%b %0d exp v=1 5", d, o[d].ov, o[d].ol);
            end
        end
        step();
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ov !== 1'b0 || o[d].ol !== letter_t'(5)) begin
                errors++;
                $display("FAIL out_hold dut%0d got v=%b %0d exp v=0 5", d, o[d].ov, o[d].ol);
            end
        end
        for (int l = 0; l < 32; l++) check_lookups("identity", l);
    endtask

    task automatic test_fixed_pairs();
        int pa [6] = '{2, 11, 12, 5, 15, 18};
        int pb [6] = '{1, 13, 25, 21, 16, 19};
        int lk [5] = '{2, 1, 25, 19, 3};
        do_reset();
        for (int i = 0; i < 6; i++) check_loads("fixed", pa[i], pb[i]);
        check_count("fixed");
        foreach (lk[i]) check_lookups("fixed", lk[i]);
    endtask

    task automatic test_rejects();
        int pa [5] = '{2, 1, 4, 0, 3};
        int pb [5] = '{1, 7, 4, 9, 27};
        int lk [4] = '{7, 4, 1, 2};
        do_reset();
        for (int i = 0; i < 5; i++) check_loads("reject", pa[i], pb[i]);
        check_count("reject");
        foreach (lk[i]) check_lookups("reject", lk[i]);
    endtask

    task automatic test_max_pairs();
        do_reset();
        check_loads("max", 1, 2);
        check_loads("max", 3, 4);
        check_loads("max", 5, 6);
        check_count("max");
        check_lookups("max", 5);
        check_lookups("max", 6);
    endtask

    task automatic test_same_cycle();
        bit e [2];
        do_reset();
        pair_a = letter_t'(7); pair_b = letter_t'(8); pair_valid = 1'b1;
        in_letter = letter_t'(7); in_valid = 1'b1;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].pr, o[d].ir} !== 2'b10) begin
                errors++;
                $display("FAIL same_cycle_ready dut%0d got %b%b exp 10", d, o[d].pr, o[d].ir);
            end
        end
        step();
        pair_valid = 1'b0;
        for (int d = 0; d < 2; d++) e[d] = model_load(d, 7, 8);
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].ok, o[d].ir} !== {e[d], 1'b1}) begin
                errors++;
                $display("FAIL same_cycle_next dut%0d ok/ir got %b%b exp %b1", d, o[d].ok, o[d].ir, e[d]);
            end
        end
        step();
        in_valid = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ov !== 1'b1 || o[d].ol !== letter_t'(mp[d][7])) begin
                errors++;
                $display("FAIL same_cycle_lookup dut%0d got v=%b %0d exp v=1 %0d",
                         d, o[d].ov, o[d].ol, mp[d][7]);
            end
        end
    endtask

    task automatic test_clear();
        int n = 0, rdy = 0;
        int lk [6] = '{3, 9, 10, 20, 14, 22};
        do_reset();
        check_loads("clear", 3, 9);
        check_loads("clear", 10, 20);
        check_loads("clear", 14, 22);
        in_letter = letter_t'(3);
        in_valid = 1'b1;
        clr_req = 1'b1;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].pr, o[d].ir} !== 2'b00) begin
                errors++;
                $display("FAIL clr_blocks_ready dut%0d got %b%b exp 00", d, o[d].pr, o[d].ir);
            end
        end
        step();
        clr_req = 1'b0;
        model_clear();
        sample();
        check_count("clear_start");
        while ((o[0].busy || o[1].busy) && n < 40) begin
            if (o[0].ir || o[1].ir) rdy++;
            step();
            sample();
            n++;
        end
        in_valid = 1'b0;
        check_sweep("clr", n, rdy);
        step();
        foreach (lk[i]) check_lookups("clear", lk[i]);
        check_loads("abort", 1, 5);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({o[d].busy, o[d].ov} !== 2'b10) begin
                errors++;
                $display("FAIL abort_state dut%0d busy/ov got %b%b exp 10", d, o[d].busy, o[d].ov);
            end
        end
        wait_idle(n);
        check_sweep("abort", n, 0);
        model_clear();
        check_lookups("abort", 1);
        check_lookups("abort", 5);
        in_letter = letter_t'(4);
        in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        sample();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o[d].ov !== 1'b0) begin
                errors++;
                $display("FAIL lookup_abort dut%0d out_valid got %b exp 0", d, o[d].ov);
            end
        end
        wait_idle(n);
        model_clear();
    endtask

    task automatic test_random();
        int n, a, b, r;
        bit e [2];
        do_reset();
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                clr_req = 1'b1;
                pair_valid = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                #1;
                sample();
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if ({o[d].pr, o[d].ir} !== 2'b00) begin
                        errors++;
                        $display("FAIL rnd_clr_ready dut%0d got %b%b exp 00", d, o[d].pr, o[d].ir);
                    end
                end
                step();
                clr_req = 1'b0; pair_valid = 1'b0; in_valid = 1'b0;
                model_clear();
                wait_idle(n);
                check_sweep("rnd_clr", n, 0);
            end else if (r < 55) begin
                a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 26));
                b = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 26));
                pair_a = letter_t'(a); pair_b = letter_t'(b); pair_valid = 1'b1;
                in_letter = letter_t'($urandom_range(0, 31));
                in_valid = 1'($urandom_range(0, 1));
                #1;
                sample();
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if ({o[d].pr, o[d].ir} !== 2'b10) begin
                        errors++;
                        $display("FAIL rnd_pair_ready dut%0d got %b%b exp 10", d, o[d].pr, o[d].ir);
                    end
                end
                step();
                pair_valid = 1'b0; in_valid = 1'b0;
                sample();
                for (int d = 0; d < 2; d++) e[d] = model_load(d, a, b);
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if ({o[d].ok, o[d].err, o[d].ov} !== {e[d], !e[d], 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_pair(%0d,%0d) dut%0d ok/err/ov got %b%b%b exp %b%b0",
                                 a, b, d, o[d].ok, o[d].err, o[d].ov, e[d], !e[d]);
                    end
                end
                check_count("rnd");
            end else begin
                check_lookups("rnd", int'($urandom_range(0, 31)));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        model_clear();
        test_reset();
        test_fixed_pairs();
        test_rejects();
        test_max_pairs();
        test_same_cycle();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
